// File: rtl/word6_tx_pkg.sv
// word6_tx_pkg
//   Shared types and constants for the 6-bit serial transmitter slice.
//   - tx_state_t : transmitter FSM states (PARITY is only reached when the
//                  WORD6_TX_PARITY_EN build option is defined)
//   - DATA_W     : word width delivered by the byte-to-6-bit FIFO
//   - IDLE_LEVEL : level of the serial line between frames
package word6_tx_pkg;

    localparam int   DATA_W     = 6;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/word6_bit_timer.sv
// word6_bit_timer
//   Reloadable down-counter that measures one serial bit period.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     load         : reload to CLKS_PER_BIT-1 (first cycle of a new bit)
//     clear        : force the count to zero
//     tick         : high on the last cycle of the current bit (count == 0)
//   The counter parks at zero, so tick stays high while nothing is timed;
//   the owner only looks at tick in states that are actually timing a bit.
module word6_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic clear,
    output logic tick
);

    localparam int              TW     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0]   RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/word6_serial_tx.sv
// word6_serial_tx
//   Pops 6-bit words from the conversion FIFO and sends each one as an
//   asynchronous frame: start bit (0), 6 data bits LSB first, stop bit (1).
//   Build option: define WORD6_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (9-bit frame).
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     enable        : permits starting new frames (sampled in IDLE and on the
//                     final stop cycle only)
//     fifo_empty    : FIFO empty flag
//     fifo_data     : FIFO read data, valid the cycle after fifo_read_en
//     fifo_read_en  : one-cycle pop request
//     tx_out        : serial line, idle high
//     busy          : high from the pop request to the end of the stop bit
//     frame_done    : pulse on the last cycle of the stop bit
//     frame_cnt     : frames completed since reset (wraps)
module word6_serial_tx
    import word6_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt
);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              tick;
    logic              tmr_load;
    logic              tmr_clear;
    logic              start_next;
    logic              last_bit;
`ifdef WORD6_TX_PARITY_EN
    logic              par_bit;
`endif

    assign start_next = enable && !fifo_empty;
    assign last_bit   = (bit_idx == 3'(DATA_W - 1));
    assign tmr_clear  = (state == IDLE);

    word6_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .tick    (tick)
    );

    // Outputs are decoded from the registered state so that an asynchronous
    // reset drives the line idle-high immediately.
    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tx_out       = IDLE_LEVEL;
        fifo_read_en = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_next) state_nxt = REQ;
            end
            REQ: begin
                fifo_read_en = 1'b1;
                state_nxt    = LOAD;
            end
            LOAD: begin
                tmr_load  = 1'b1;
                state_nxt = START;
            end
            START: begin
                tx_out = 1'b0;
                if (tick) begin
                    tmr_load  = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_out = shreg[0];
                if (tick) begin
                    tmr_load = 1'b1;
`ifdef WORD6_TX_PARITY_EN
                    if (last_bit) state_nxt = PARITY;
`else
                    if (last_bit) state_nxt = STOP;
`endif
                end
            end
`ifdef WORD6_TX_PARITY_EN
            PARITY: begin
                tx_out = par_bit;
                if (tick) begin
                    tmr_load  = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // No reload here: the next frame passes through LOAD, which
                // restarts the timer, so REQ/LOAD form the whole gap.
                if (tick) begin
                    frame_done = 1'b1;
                    state_nxt  = start_next ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
`ifdef WORD6_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                shreg   <= fifo_data;
                bit_idx <= '0;
`ifdef WORD6_TX_PARITY_EN
                par_bit <= ^fifo_data;
`endif
            end else if (state == DATA && tick) begin
                shreg   <= {1'b0, shreg[DATA_W-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_word6_serial_tx.sv
module tb_word6_serial_tx;

    localparam int CPB   = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic [5:0] word;
        logic [8:0] bits;   // line levels in time order, first bit at [nbits-1]
        int         nbits;
    } frame_t;

    // Hand-derived line sequences: start, d0..d5, (parity), stop.
`ifdef WORD6_TX_PARITY_EN
    localparam int         NB   = 9;
    localparam logic [8:0] B_2D = 9'b0_101101_0_1;
    localparam logic [8:0] B_3F = 9'b0_111111_0_1;
    localparam logic [8:0] B_00 = 9'b0_000000_0_1;
    localparam logic [8:0] B_15 = 9'b0_101010_1_1;
    localparam logic [8:0] B_07 = 9'b0_111000_1_1;
`else
    localparam int         NB   = 8;
    localparam logic [8:0] B_2D = 9'b0_0_101101_1;
    localparam logic [8:0] B_3F = 9'b0_0_111111_1;
    localparam logic [8:0] B_00 = 9'b0_0_000000_1;
    localparam logic [8:0] B_15 = 9'b0_0_101010_1;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             fifo_empty;
    logic [5:0]       fifo_data;
    logic             fifo_read_en;
    logic             tx_out;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt;

    logic [5:0] fifo_q[$];
    frame_t     exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_frames = 0;
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;

    word6_serial_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .tx_out       (tx_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [5:0] w, input logic [8:0] bits, input bit expect_tx);
        frame_t f;
        f.word  = w;
        f.bits  = bits;
        f.nbits = NB;
        fifo_q.push_back(w);
        if (expect_tx) exp_q.push_back(f);
    endtask

    task automatic wait_rd(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (fifo_read_en) ok = 1'b1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy && !busy) ok = 1'b1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    // FIFO model: pop sampled mid-cycle, data presented just after the edge.
    initial begin
        bit rd_lat;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(negedge clk);
            rd_lat = fifo_read_en;
            @(posedge clk);
            #1;
            if (rd_lat && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: every pop starts a frame; compare the whole cycle-level waveform.
    initial begin
        bit         pend = 1'b0;
        bit         b2b;
        frame_t     e;
        int         len;
        int         rd_bad;
        logic [63:0] act_tx, exp_tx, act_bsy, act_dn, exp_dn;
        forever begin
            if (!pend) begin
                @(negedge clk);
                if (!(mon_en && reset_n && fifo_read_en)) continue;
                b2b = 1'b0;
            end else begin
                b2b = 1'b1;
            end
            pend     = 1'b0;
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pop expected none");
                e.word = '0; e.bits = 9'h001; e.nbits = NB;
            end else begin
                e = exp_q.pop_front();
            end
            len    = 2 + e.nbits * CPB;
            exp_tx = 64'b11;
            for (int b = e.nbits - 1; b >= 0; b--)
                for (int k = 0; k < CPB; k++) exp_tx = {exp_tx[62:0], e.bits[b]};
            act_tx = '0; act_bsy = '0; act_dn = '0; rd_bad = 0;
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge clk);
                act_tx  = {act_tx[62:0], tx_out};
                act_bsy = {act_bsy[62:0], busy};
                act_dn  = {act_dn[62:0], frame_done};
                if (i == 1) chk("frame_cnt_at_load", 64'(frame_cnt), 64'(exp_frames));
                if (i > 0 && i < len - 1 && fifo_read_en) rd_bad++;
                if (i == len - 1) pend = fifo_read_en && mon_en;
            end
            exp_dn = 64'd1 | (b2b ? (64'd1 << (len - 1)) : 64'd0);
            chk($sformatf("tx_wave_%h", e.word), act_tx, exp_tx);
            chk($sformatf("busy_wave_%h", e.word), act_bsy, (64'd1 << len) - 64'd1);
            chk($sformatf("done_wave_%h", e.word), act_dn, exp_dn);
            chk($sformatf("extra_pop_%h", e.word), 64'(rd_bad), 64'd0);
            exp_frames++;
            mon_busy = 1'b0;
        end
    end

    initial begin
        int rd_n, busy_n, low_n;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",   64'(tx_out), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt",  64'(frame_cnt), 64'd0);
        chk("rst_rd",   64'(fifo_read_en), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);

        // single word
        push_word(6'h2D, B_2D, 1'b1);
        wait_idle("idle_single");
        chk("cnt_single", 64'(frame_cnt), 64'd1);

        // back-to-back
        push_word(6'h3F, B_3F, 1'b1);
        push_word(6'h00, B_00, 1'b1);
        wait_idle("idle_b2b");
        chk("cnt_b2b", 64'(frame_cnt), 64'd3);

        // enable dropped mid-frame; second word must stay queued
        push_word(6'h15, B_15, 1'b1);
        push_word(6'h2A, 9'h0, 1'b0);
        wait_rd("rd_enable_drop");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle("idle_enable_drop");
        rd_n = 0;
        repeat (40) begin @(negedge clk); if (fifo_read_en) rd_n++; end
        chk("no_pop_disabled", 64'(rd_n), 64'd0);
        chk("fifo_left", 64'(fifo_q.size()), 64'd1);
        chk("cnt_enable_drop", 64'(frame_cnt), 64'd4);
        fifo_q.delete();
        repeat (3) @(negedge clk);

        // empty FIFO with enable high
        enable = 1'b1;
        rd_n = 0; busy_n = 0; low_n = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_read_en) rd_n++;
            if (busy) busy_n++;
            if (tx_out !== 1'b1) low_n++;
        end
        chk("empty_rd",   64'(rd_n), 64'd0);
        chk("empty_busy", 64'(busy_n), 64'd0);
        chk("empty_line", 64'(low_n), 64'd0);

`ifdef WORD6_TX_PARITY_EN
        push_word(6'h07, B_07, 1'b1);
        wait_idle("idle_parity");
        chk("cnt_parity", 64'(frame_cnt), 64'd5);
`endif

        // reset in the middle of DATA
        mon_en = 1'b0;
        push_word(6'h2D, 9'h0, 1'b0);
        wait_rd("rd_mid_reset");
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_tx",   64'(tx_out), 64'd1);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_cnt",  64'(frame_cnt), 64'd0);
        chk("mrst_done", 64'(frame_done), 64'd0);
        chk("mrst_rd",   64'(fifo_read_en), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_n = 0; busy_n = 0; low_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_read_en) rd_n++;
            if (busy) busy_n++;
            if (tx_out !== 1'b1) low_n++;
        end
        chk("post_rst_rd",   64'(rd_n), 64'd0);
        chk("post_rst_busy", 64'(busy_n), 64'd0);
        chk("post_rst_line", 64'(low_n), 64'd0);

        // counter restarts from zero
        exp_frames = 0;
        mon_en     = 1'b1;
        push_word(6'h3F, B_3F, 1'b1);
        wait_idle("idle_after_reset");
        chk("cnt_after_reset", 64'(frame_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
